// File: rtl/pll_phase_ctrl_if.sv
// Request/status/readback bundle between the link alignment logic and pll_phase_ctrl.
// master = alignment logic, slave = phase controller.
interface pll_phase_ctrl_if #(
    parameter int STEP_W = 8,
    parameter int POS_W  = 6
);
    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               req_ch;
    logic signed [STEP_W-1:0] req_steps;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic                     err_clr;
    logic [1:0]               pos_rd_ch;
    logic [POS_W-1:0]         pos_rd;

    modport master (
        output req_valid, req_ch, req_steps, err_clr, pos_rd_ch,
        input  req_ready, busy, done, err, pos_rd
    );

    modport slave (
        input  req_valid, req_ch, req_steps, err_clr, pos_rd_ch,
        output req_ready, busy, done, err, pos_rd
    );
endinterface

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-adjust sequencer for the ECP5 EHXPLLL with per-channel position tracking.
// Optional macro PLL_PHASE_LOAD_EN adds a PHASELOADREG pulse (LOAD state) before completion.
module pll_phase_ctrl #(
    parameter int N_CH         = 4,
    parameter int STEP_W       = 8,
    parameter int SETUP_CYC    = 4,
    parameter int STEP_HI_CYC  = 4,
    parameter int STEP_GAP_CYC = 8,
    parameter int POS_MOD      = 64,
    parameter int POS_W        = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    pll_phase_ctrl_if.slave ctl,
    input  logic            pll_lock_i,
    output logic [1:0]      phasesel_o,
    output logic            phasedir_o,
    output logic            phasestep_o,
    output logic            phaseloadreg_o
);
    localparam int CNT_W = 16;

`ifdef PLL_PHASE_LOAD_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP_HI, S_STEP_GAP, S_LOAD, S_FIN} state_t;
    localparam state_t S_POST = S_LOAD;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP_HI, S_STEP_GAP, S_FIN} state_t;
    localparam state_t S_POST = S_FIN;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, gap_last;
    logic [STEP_W-1:0] rem_q, rem_d, mag;
    logic [POS_W-1:0]  pos_q [N_CH];
    logic [POS_W-1:0]  pos_rd_q;
    logic [1:0]        phasesel_q;
    logic              phasedir_q, phasestep_q, busy_q, done_q, err_q;
    logic              lock_meta_q, lock_s_q;
    logic              accept, ch_bad, pos_step, set_err;

    function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] p, input logic dn);
        if (dn)
            return (p == '0) ? POS_W'(POS_MOD - 1) : p - POS_W'(1);
        return (p == POS_W'(POS_MOD - 1)) ? '0 : p + POS_W'(1);
    endfunction

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign ctl.req_ready = (state_q == S_IDLE) & lock_s_q & ~err_q;
    assign accept        = ctl.req_valid & ctl.req_ready;
    assign ch_bad        = {1'b0, ctl.req_ch} >= 3'(N_CH);
    assign mag           = ctl.req_steps[STEP_W-1] ? $unsigned(-ctl.req_steps)
                                                   : $unsigned(ctl.req_steps);

    // The final gap is one cycle short so the trailing LOAD/FIN cycle completes the low gap;
    // that keeps DONE at SETUP_CYC + n*(STEP_HI_CYC+STEP_GAP_CYC) after accept.
    assign gap_last = (rem_q == '0) ? CNT_W'(STEP_GAP_CYC - 2) : CNT_W'(STEP_GAP_CYC - 1);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        rem_d    = rem_q;
        pos_step = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (ch_bad)
                        set_err = 1'b1;
                    else if (mag == '0)
                        state_d = S_POST;
                    else begin
                        state_d = S_SETUP;
                        rem_d   = mag;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = S_STEP_HI;
                    cnt_d   = '0;
                end
            end
            S_STEP_HI: begin
                if (cnt_q == CNT_W'(STEP_HI_CYC - 1)) begin
                    pos_step = 1'b1;
                    rem_d    = rem_q - STEP_W'(1);
                    cnt_d    = '0;
                    state_d  = (rem_q == STEP_W'(1) && STEP_GAP_CYC == 1) ? S_POST : S_STEP_GAP;
                end
            end
            S_STEP_GAP: begin
                if (cnt_q == gap_last) begin
                    cnt_d   = '0;
                    state_d = (rem_q == '0) ? S_POST : S_STEP_HI;
                end
            end
`ifdef PLL_PHASE_LOAD_EN
            S_LOAD: begin
                if (cnt_q == CNT_W'(STEP_HI_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Lock loss aborts; a pulse cut short here never reaches its position update.
        if (state_q != S_IDLE && !lock_s_q) begin
            state_d  = S_IDLE;
            pos_step = 1'b0;
            set_err  = 1'b1;
        end
    end

    // NOTE: the position array is reset with the rest of the state because software reads it back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            phasesel_q  <= '0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pos_rd_q    <= '0;
            for (int i = 0; i < N_CH; i++) pos_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            if (accept && state_d == S_SETUP) begin
                phasesel_q <= ctl.req_ch;
                phasedir_q <= ctl.req_steps[STEP_W-1];
            end
            phasestep_q <= (state_d == S_STEP_HI);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIN);
            err_q       <= set_err | (err_q & ~ctl.err_clr);
            for (int i = 0; i < N_CH; i++) begin
                if (pos_step && phasesel_q == 2'(i))
                    pos_q[i] <= pos_next(pos_q[i], phasedir_q);
            end
            pos_rd_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (ctl.pos_rd_ch == 2'(i))
                    pos_rd_q <= pos_q[i];
            end
        end
    end

`ifdef PLL_PHASE_LOAD_EN
    logic phaseloadreg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phaseloadreg_q <= 1'b0;
        else
            phaseloadreg_q <= (state_d == S_LOAD);
    end

    assign phaseloadreg_o = phaseloadreg_q;
`else
    assign phaseloadreg_o = 1'b0;
`endif

    assign phasesel_o  = phasesel_q;
    assign phasedir_o  = phasedir_q;
    assign phasestep_o = phasestep_q;
    assign ctl.busy    = busy_q;
    assign ctl.done    = done_q;
    assign ctl.err     = err_q;
    assign ctl.pos_rd  = pos_rd_q;
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: vector table of step requests plus hand-written
// sequences for lock loss, bad channel, ERR_CLR collision and mid-sequence reset.
module tb_pll_phase_ctrl;
    localparam int STEP_W = 8;
    localparam int POS_W  = 6;
`ifdef PLL_PHASE_LOAD_EN
    localparam int LOAD_EXTRA = 4;
`else
    localparam int LOAD_EXTRA = 0;
`endif

    typedef struct {
        logic [1:0]               ch;
        logic signed [STEP_W-1:0] steps;
        logic                     dir;
        int                       pulses;
        int                       lat;
        int                       pos;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       lock2 = 1'b0;
    logic [1:0] phasesel, phasesel2;
    logic       phasedir, phasestep, phaseloadreg;
    logic       phasedir2, phasestep2, phaseloadreg2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    pll_phase_ctrl_if #(.STEP_W(STEP_W), .POS_W(POS_W)) bus ();
    pll_phase_ctrl_if #(.STEP_W(STEP_W), .POS_W(POS_W)) bus2 ();

    pll_phase_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctl            (bus.slave),
        .pll_lock_i     (lock),
        .phasesel_o     (phasesel),
        .phasedir_o     (phasedir),
        .phasestep_o    (phasestep),
        .phaseloadreg_o (phaseloadreg)
    );

    pll_phase_ctrl #(.N_CH(2)) u_dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctl            (bus2.slave),
        .pll_lock_i     (lock2),
        .phasesel_o     (phasesel2),
        .phasedir_o     (phasedir2),
        .phasestep_o    (phasestep2),
        .phaseloadreg_o (phaseloadreg2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.req_ready), 1);
    endtask

    // Drives one accepted request; returns at the first negedge after the accept edge (k=1).
    task automatic send(input logic [1:0] ch, input logic signed [STEP_W-1:0] steps);
        bus.req_ch    = ch;
        bus.req_steps = steps;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic read_pos(input string name, input logic [1:0] ch, input int exp);
        bus.pos_rd_ch = ch;
        @(negedge clk);
        @(negedge clk);
        check(name, 32'(bus.pos_rd), exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   pulses = 0, hi = 0, n_done = 0, first_done = -1, load_cyc = 0;
        int   last_rise = -1, gap_err = 0, sel_err = 0, first_rise = -1;
        logic prev = 1'b0;
        wait_ready($sformatf("v%0d_ready", idx));
        send(v.ch, v.steps);
        check($sformatf("v%0d_busy_k1", idx), 32'(bus.busy), 1);
        for (int k = 1; k <= v.lat + LOAD_EXTRA + 6; k++) begin
            if (phasestep && !prev) begin
                pulses++;
                if (first_rise < 0) first_rise = k;
                if (last_rise >= 0 && k - last_rise != 12) gap_err++;
                if (phasesel !== v.ch || phasedir !== v.dir) sel_err++;
                last_rise = k;
            end
            if (phasestep) hi++;
            if (phaseloadreg) load_cyc++;
            if (bus.done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            prev = phasestep;
            @(negedge clk);
        end
        check($sformatf("v%0d_pulses", idx), 32'(pulses), 32'(v.pulses));
        check($sformatf("v%0d_hi_cycles", idx), 32'(hi), 32'(4 * v.pulses));
        check($sformatf("v%0d_period_err", idx), 32'(gap_err), 0);
        check($sformatf("v%0d_sel_dir_err", idx), 32'(sel_err), 0);
        if (v.pulses > 0)
            check($sformatf("v%0d_first_rise", idx), 32'(first_rise), 5);
        check($sformatf("v%0d_done_at", idx), 32'(first_done), 32'(v.lat + LOAD_EXTRA));
        check($sformatf("v%0d_done_cnt", idx), 32'(n_done), 1);
        check($sformatf("v%0d_load_cyc", idx), 32'(load_cyc), 32'(LOAD_EXTRA));
        check($sformatf("v%0d_busy_end", idx), 32'(bus.busy), 0);
        read_pos($sformatf("v%0d_pos", idx), v.ch, v.pos);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        int   fall, n_done, act;

        vecs[0] = '{ch: 2'd2, steps:  8'sd3,   dir: 1'b0, pulses: 3,   lat: 40,   pos: 3};
        vecs[1] = '{ch: 2'd1, steps: -8'sd2,   dir: 1'b1, pulses: 2,   lat: 28,   pos: 62};
        vecs[2] = '{ch: 2'd0, steps:  8'sd0,   dir: 1'b0, pulses: 0,   lat: 1,    pos: 0};
        vecs[3] = '{ch: 2'd3, steps:  8'sd1,   dir: 1'b0, pulses: 1,   lat: 16,   pos: 1};
        vecs[4] = '{ch: 2'd3, steps: -8'sd1,   dir: 1'b1, pulses: 1,   lat: 16,   pos: 0};
        vecs[5] = '{ch: 2'd1, steps:  8'sd3,   dir: 1'b0, pulses: 3,   lat: 40,   pos: 1};
        vecs[6] = '{ch: 2'd0, steps: -8'sd128, dir: 1'b1, pulses: 128, lat: 1540, pos: 0};

        bus.req_valid  = 1'b0; bus.req_ch  = '0; bus.req_steps  = '0;
        bus.err_clr    = 1'b0; bus.pos_rd_ch  = '0;
        bus2.req_valid = 1'b0; bus2.req_ch = '0; bus2.req_steps = '0;
        bus2.err_clr   = 1'b0; bus2.pos_rd_ch = '0;

        // Reset values, then lock synchroniser latency on REQ_READY.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_step", 32'(phasestep), 0);
        check("rst_sel", 32'(phasesel), 0);
        check("rst_pos_rd", 32'(bus.pos_rd), 0);
        rst_n = 1'b1;
        @(negedge clk);
        lock  = 1'b1;
        lock2 = 1'b1;
        @(negedge clk);
        check("ready_sync_lag", 32'(bus.req_ready), 0);
        @(negedge clk);
        check("ready_after_lock", 32'(bus.req_ready), 1);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
        read_pos("pos_ch2_kept", 2'd2, 3);

        // Lock loss during the third STEP_HI of a +5 request on channel 2.
        wait_ready("ld_ready");
        send(2'd2, 8'sd5);
        repeat (29) @(negedge clk);
        check("ld_in_hi3", 32'(phasestep), 1);
        lock   = 1'b0;
        fall   = 0;
        n_done = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (!phasestep && fall == 0) fall = j;
            if (bus.done) n_done++;
        end
        check("ld_step_low_by3", 32'(fall >= 1 && fall <= 3), 1);
        check("ld_err", 32'(bus.err), 1);
        check("ld_busy", 32'(bus.busy), 0);
        check("ld_no_done", 32'(n_done), 0);
        check("ld_ready_low", 32'(bus.req_ready), 0);
        lock = 1'b1;
        repeat (4) @(negedge clk);
        check("ld_ready_held_by_err", 32'(bus.req_ready), 0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("ld_err_cleared", 32'(bus.err), 0);
        check("ld_ready_back", 32'(bus.req_ready), 1);
        read_pos("ld_pos_plus2", 2'd2, 5);

        // Two-channel instance: out-of-range channel, ERR_CLR, and ERR_CLR colliding with a new error.
        check("b2_ready", 32'(bus2.req_ready), 1);
        bus2.req_ch    = 2'd3;
        bus2.req_steps = 8'sd5;
        bus2.req_valid = 1'b1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        act = 0;
        for (int j = 0; j < 20; j++) begin
            if (phasestep2 || bus2.done || bus2.busy) act++;
            @(negedge clk);
        end
        check("b2_no_activity", 32'(act), 0);
        check("b2_err", 32'(bus2.err), 1);
        check("b2_ready_low", 32'(bus2.req_ready), 0);
        for (int c = 0; c < 2; c++) begin
            bus2.pos_rd_ch = 2'(c);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("b2_pos%0d", c), 32'(bus2.pos_rd), 0);
        end
        bus2.err_clr = 1'b1;
        @(negedge clk);
        bus2.err_clr = 1'b0;
        check("b2_err_cleared", 32'(bus2.err), 0);
        check("b2_ready_back", 32'(bus2.req_ready), 1);
        bus2.req_ch    = 2'd2;
        bus2.req_valid = 1'b1;
        bus2.err_clr   = 1'b1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        bus2.err_clr   = 1'b0;
        check("b2_collide_err", 32'(bus2.err), 1);
        bus2.err_clr = 1'b1;
        @(negedge clk);
        bus2.err_clr   = 1'b0;
        bus2.req_ch    = 2'd1;
        bus2.req_steps = 8'sd1;
        bus2.req_valid = 1'b1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        n_done = 0;
        for (int j = 0; j < 20; j++) begin
            if (bus2.done) n_done++;
            @(negedge clk);
        end
        check("b2_ok_done", 32'(n_done), 1);
        bus2.pos_rd_ch = 2'd1;
        @(negedge clk);
        @(negedge clk);
        check("b2_ok_pos1", 32'(bus2.pos_rd), 1);

        // Reset asserted mid-sequence clears outputs and positions immediately.
        bus.pos_rd_ch = 2'd3;
        wait_ready("mr_ready");
        send(2'd3, 8'sd4);
        repeat (21) @(negedge clk);
        check("mr_busy_before", 32'(bus.busy), 1);
        check("mr_pos_before", 32'(bus.pos_rd), 2);
        rst_n = 1'b0;
        #1;
        check("mr_busy_async", 32'(bus.busy), 0);
        check("mr_step_async", 32'(phasestep), 0);
        check("mr_sel_async", 32'(phasesel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("mr_ready_after");
        for (int c = 0; c < 4; c++) read_pos($sformatf("mr_pos%0d", c), 2'(c), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
